fb_fill: RTL and testbench



---
 rtl/fb_pkg.sv | 19 +
 rtl/fb_fill_if.sv | 28 ++
 rtl/fb_fill_setup.sv | 37 +++
 rtl/fb_fill.sv | 138 +++++++++++++
 tb/tb_fb_fill.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer geometry, widths and fill FSM state type
package fb_pkg;

    localparam int H_RES = 320;
    localparam int V_RES = 200;

    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int ADR_W = 16;
    localparam int COL_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FILL,
        DONE
    } fb_fill_state_t;

endpackage

// File: rtl/fb_fill_if.sv
// rtl/fb_fill_if.sv - fill command handshake, status and framebuffer write port bundle
interface fb_fill_if;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [fb_pkg::X_W-1:0]   cmd_x0;
    logic [fb_pkg::X_W-1:0]   cmd_x1;
    logic [fb_pkg::Y_W-1:0]   cmd_y0;
    logic [fb_pkg::Y_W-1:0]   cmd_y1;
    logic [fb_pkg::COL_W-1:0] cmd_color;
    logic                     busy;
    logic                     done;
    logic                     fb_wclk;
    logic [fb_pkg::ADR_W-1:0] fb_wadr;
    logic                     fb_we;
    logic [fb_pkg::COL_W-1:0] fb_d;

    modport master (
        output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
        input  cmd_ready, busy, done, fb_wclk, fb_wadr, fb_we, fb_d
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
        output cmd_ready, busy, done, fb_wclk, fb_wadr, fb_we, fb_d
    );

endinterface

// File: rtl/fb_fill_setup.sv
// rtl/fb_fill_setup.sv - corner ordering, optional clipping (FB_FILL_CLIP_EN) and row base address
module fb_fill_setup
    import fb_pkg::*;
(
    input  logic [X_W-1:0]   x0,
    input  logic [X_W-1:0]   x1,
    input  logic [Y_W-1:0]   y0,
    input  logic [Y_W-1:0]   y1,
    output logic [X_W-1:0]   xs,
    output logic [X_W-1:0]   xe,
    output logic [Y_W-1:0]   ys,
    output logic [Y_W-1:0]   ye,
    output logic [ADR_W-1:0] row_base,
    output logic             empty
);

`ifdef FB_FILL_CLIP_EN
    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);
`endif

    always_comb begin
        xs    = (x0 < x1) ? x0 : x1;
        xe    = (x0 < x1) ? x1 : x0;
        ys    = (y0 < y1) ? y0 : y1;
        ye    = (y0 < y1) ? y1 : y0;
        empty = 1'b0;
`ifdef FB_FILL_CLIP_EN
        if (xe > X_LAST) xe = X_LAST;
        if (ye > Y_LAST) ye = Y_LAST;
        empty = (xs > X_LAST) || (ys > Y_LAST);
`endif
        // ys*320 as ys*256 + ys*64
        row_base = (ADR_W'(ys) << 8) + (ADR_W'(ys) << 6);
    end

endmodule

// File: rtl/fb_fill.sv
// rtl/fb_fill.sv - rectangle fill engine driving the framebuffer write port; clipping via FB_FILL_CLIP_EN
module fb_fill
    import fb_pkg::*;
(
    input  logic     CLOCK_50,
    input  logic     rst_n,
    fb_fill_if.slave bus
);

    fb_fill_state_t   state_q, state_d;
    logic [X_W-1:0]   x0_q, x0_d, x1_q, x1_d;
    logic [Y_W-1:0]   y0_q, y0_d, y1_q, y1_d;
    logic [COL_W-1:0] color_q, color_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [ADR_W-1:0] row_base_q, row_base_d;
    logic             fb_we_q, fb_we_d;
    logic [ADR_W-1:0] fb_wadr_q, fb_wadr_d;
    logic [COL_W-1:0] fb_d_q, fb_d_d;

    logic [X_W-1:0]   xs, xe;
    logic [Y_W-1:0]   ys, ye;
    logic [ADR_W-1:0] setup_row_base;
    logic             empty;

    // Latched command stays stable for the whole fill, so setup outputs stay valid in FILL too
    fb_fill_setup u_setup (
        .x0       (x0_q),
        .x1       (x1_q),
        .y0       (y0_q),
        .y1       (y1_q),
        .xs       (xs),
        .xe       (xe),
        .ys       (ys),
        .ye       (ye),
        .row_base (setup_row_base),
        .empty    (empty)
    );

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        color_d    = color_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        fb_we_d    = 1'b0;
        fb_wadr_d  = '0;
        fb_d_d     = '0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    x0_d    = bus.cmd_x0;
                    x1_d    = bus.cmd_x1;
                    y0_d    = bus.cmd_y0;
                    y1_d    = bus.cmd_y1;
                    color_d = bus.cmd_color;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (empty) begin
                    state_d = DONE;
                end else begin
                    x_d        = xs;
                    y_d        = ys;
                    row_base_d = setup_row_base;
                    fb_we_d    = 1'b1;
                    fb_wadr_d  = setup_row_base + ADR_W'(xs);
                    fb_d_d     = color_q;
                    state_d    = FILL;
                end
            end
            FILL: begin
                // Output registers hold the pixel being written; compute the one after it
                if (x_q != xe) begin
                    x_d       = x_q + 1'b1;
                    fb_we_d   = 1'b1;
                    fb_wadr_d = fb_wadr_q + 1'b1;
                    fb_d_d    = color_q;
                end else if (y_q != ye) begin
                    x_d        = xs;
                    y_d        = y_q + 1'b1;
                    row_base_d = row_base_q + ADR_W'(H_RES);
                    fb_we_d    = 1'b1;
                    fb_wadr_d  = row_base_q + ADR_W'(H_RES) + ADR_W'(xs);
                    fb_d_d     = color_q;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            x1_q       <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            color_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            fb_we_q    <= 1'b0;
            fb_wadr_q  <= '0;
            fb_d_q     <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            color_q    <= color_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            fb_we_q    <= fb_we_d;
            fb_wadr_q  <= fb_wadr_d;
            fb_d_q     <= fb_d_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.fb_wclk   = CLOCK_50;
    assign bus.fb_we     = fb_we_q;
    assign bus.fb_wadr   = fb_wadr_q;
    assign bus.fb_d      = fb_d_q;

endmodule

// File: tb/tb_fb_fill.sv
// tb/tb_fb_fill.sv - randomized self-checking bench for fb_fill against a pixel-list reference model
module tb_fb_fill;
    import fb_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   exp_q[$];

    fb_fill_if u_if ();

    fb_fill dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .bus      (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: list every pixel address of the ordered (and optionally clamped) rectangle
    task automatic build_exp(input int x0, input int x1, input int y0, input int y1);
        int xs, xe, ys, ye;
        exp_q.delete();
        xs = (x0 < x1) ? x0 : x1;
        xe = (x0 < x1) ? x1 : x0;
        ys = (y0 < y1) ? y0 : y1;
        ye = (y0 < y1) ? y1 : y0;
`ifdef FB_FILL_CLIP_EN
        if (xe > H_RES - 1) xe = H_RES - 1;
        if (ye > V_RES - 1) ye = V_RES - 1;
`endif
        for (int y = ys; y <= ye; y++)
            for (int x = xs; x <= xe; x++)
                exp_q.push_back((y * H_RES + x) & 16'hFFFF);
    endtask

    // Entered and left at a negedge; keep=1 holds cmd_valid high with junk through the fill and done
    task automatic run_cmd(input int x0, input int x1, input int y0, input int y1,
                           input logic [23:0] col, input bit keep);
        int  n, widx;
        bit  got_done;
        build_exp(x0, x1, y0, y1);
        n = exp_q.size();
        for (int w = 0; w < 8 && !u_if.cmd_ready; w++) @(negedge clk);
        chk("ready_accept", 32'(u_if.cmd_ready), 1);
        u_if.cmd_x0    = 9'(x0);
        u_if.cmd_x1    = 9'(x1);
        u_if.cmd_y0    = 8'(y0);
        u_if.cmd_y1    = 8'(y1);
        u_if.cmd_color = col;
        u_if.cmd_valid = 1'b1;
        @(posedge clk);
        widx = 0;
        got_done = 1'b0;
        for (int k = 1; k <= n + 8 && !got_done; k++) begin
            @(negedge clk);
            if (keep) begin
                u_if.cmd_x0    = 9'($urandom_range(0, 319));
                u_if.cmd_x1    = 9'($urandom_range(0, 319));
                u_if.cmd_y0    = 8'($urandom_range(0, 199));
                u_if.cmd_y1    = 8'($urandom_range(0, 199));
                u_if.cmd_color = 24'($urandom);
                chk("ready_while_busy", 32'(u_if.cmd_ready), 0);
            end else begin
                u_if.cmd_valid = 1'b0;
            end
            if (k == 1) chk("busy_setup", 32'(u_if.busy), 1);
            if (u_if.fb_we) begin
                if (widx < n) begin
                    chk("wadr", 32'(u_if.fb_wadr), 32'(exp_q[widx]));
                    chk("wdata", 32'(u_if.fb_d), 32'(col));
                    chk("wcycle", 32'(k), 32'(widx + 2));
                end else begin
                    chk("extra_write", 32'(widx), 32'(n));
                end
                widx++;
            end
            if (u_if.done) begin
                got_done = 1'b1;
                chk("done_cycle", 32'(k), 32'(n + 2));
                chk("write_count", 32'(widx), 32'(n));
                chk("busy_done", 32'(u_if.busy), 1);
                chk("idle_bus", {7'd0, u_if.fb_we, u_if.fb_wadr} | 32'(u_if.fb_d), 0);
            end
        end
        if (!got_done) chk("done_seen", 0, 1);
        @(negedge clk);
        chk("ready_after_done", 32'(u_if.cmd_ready), 1);
        chk("done_single", 32'(u_if.done), 0);
    endtask

    initial begin
        int x0, x1, y0, y1;
        n_checks = 0;
        n_fail   = 0;
        rst_n          = 1'b0;
        u_if.cmd_valid = 1'b0;
        u_if.cmd_x0    = '0;
        u_if.cmd_x1    = '0;
        u_if.cmd_y0    = '0;
        u_if.cmd_y1    = '0;
        u_if.cmd_color = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(u_if.cmd_ready), 1);
        chk("rst_busy", 32'(u_if.busy), 0);
        chk("rst_done", 32'(u_if.done), 0);
        chk("rst_we", 32'(u_if.fb_we), 0);
        chk("rst_wadr", 32'(u_if.fb_wadr), 0);
        chk("rst_d", 32'(u_if.fb_d), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(5, 5, 7, 7, 24'hFF0000, 1'b0);
        run_cmd(10, 8, 3, 2, 24'h00FF00, 1'b0);
        run_cmd(20, 40, 10, 14, 24'h123456, 1'b1);
        run_cmd(103, 100, 52, 50, 24'hABCDEF, 1'b0);

        for (int i = 0; i < 16; i++) begin
            x0 = $urandom_range(0, 319);
            y0 = $urandom_range(0, 199);
            x1 = x0 + $urandom_range(0, 15);
            y1 = y0 + $urandom_range(0, 7);
            if (x1 > 319) x1 = 319;
            if (y1 > 199) y1 = 199;
            if ($urandom_range(0, 1) == 1) run_cmd(x1, x0, y1, y0, 24'($urandom), (i < 15) && ($urandom_range(0, 1) == 1));
            else                           run_cmd(x0, x1, y0, y1, 24'($urandom), (i < 15) && ($urandom_range(0, 1) == 1));
        end

        run_cmd(319, 319, 199, 199, 24'h00000F, 1'b0);

`ifdef FB_FILL_CLIP_EN
        run_cmd(300, 400, 195, 250, 24'h0F0F0F, 1'b0);
        run_cmd(330, 340, 0, 10, 24'hF0F0F0, 1'b0);
`endif

        // Reset in the middle of a fill
        u_if.cmd_x0    = 9'd20;
        u_if.cmd_x1    = 9'd39;
        u_if.cmd_y0    = 8'd50;
        u_if.cmd_y1    = 8'd54;
        u_if.cmd_color = 24'h55AA55;
        u_if.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_fill_we", 32'(u_if.fb_we), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(u_if.fb_we), 0);
        chk("arst_ready", 32'(u_if.cmd_ready), 1);
        chk("arst_busy", 32'(u_if.busy), 0);
        chk("arst_wadr", 32'(u_if.fb_wadr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(u_if.done), 0);
            chk("post_rst_we", 32'(u_if.fb_we), 0);
        end
        run_cmd(7, 2, 60, 61, 24'h777777, 1'b0);

        run_cmd(0, 319, 0, 199, 24'hC0FFEE, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
